// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit:
// FSM states, queue entry layout and the default reset PC.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HOLD
   } state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: power-of-two FIFO of {pc, inst} entries with flush.
// Push and pop in the same cycle leave the count unchanged, even when full or empty.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  fq_entry_t     i_entry,
   input  logic          i_pop,
   input  logic          i_flush,
   output fq_entry_t     o_head,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   localparam int AW = $clog2(DEPTH);

   fq_entry_t     r_mem [DEPTH];
   logic [AW-1:0] r_rd;
   logic [AW-1:0] r_wr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd];
   assign w_do_push = i_push && (!o_full || i_pop);
   assign w_do_pop  = i_pop && (!o_empty || i_push);

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push)
            r_wr <= r_wr + 1'b1;
         if (w_do_pop)
            r_rd <= r_rd + 1'b1;
         if (w_do_push && !w_do_pop)
            r_count <= r_count + 1'b1;
         else if (w_do_pop && !w_do_push)
            r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr] <= i_entry;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues I-cache lookups, rewinds on miss,
// follows redirects and buffers fetched instructions for decode.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        icache_req,
   output logic [31:0] icache_pc,
   input  logic [31:0] icache_inst,
   input  logic        icache_valid,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic [31:0] miss_count
);

   localparam int CW  = $clog2(QDEPTH + 1);
   localparam int CW1 = CW + 1;

   state_e        r_state;
   state_e        w_state_nxt;
   logic [31:0]   r_pc;
   logic [31:0]   r_inf_pc;
   logic          r_inf;
   logic [31:0]   r_miss;
   logic [CW-1:0] w_count;
   logic [CW:0]   w_occ;
   logic          w_space;
   logic          w_req;
   logic          w_full;
   logic          w_empty;
   logic          w_resp_miss;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   w_redir_pc;
   fq_entry_t     w_entry;
   fq_entry_t     w_head;

   // Queued plus in-flight entries bound the outstanding work.
   assign w_occ       = {1'b0, w_count} + {{CW{1'b0}}, r_inf};
   assign w_space     = !w_full && (w_occ < CW1'(QDEPTH));
   assign w_resp_miss = r_inf && !icache_valid;
   assign w_push      = r_inf && icache_valid && !redirect_valid && !rst;
   assign w_pop       = if_valid && if_ready && !redirect_valid && !rst;
   assign w_redir_pc  = redirect_pc & 32'hFFFF_FFFC;
   assign w_entry     = '{pc: r_inf_pc, inst: icache_inst};

   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_req       = w_space;
            w_state_nxt = S_RUN;
         end
         S_RUN, S_HOLD: begin
            w_req       = w_space;
            w_state_nxt = w_space ? S_RUN : S_HOLD;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (redirect_valid) begin
         w_req       = 1'b0;
         w_state_nxt = S_RUN;
      end
      if (rst) begin
         w_req       = 1'b0;
         w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc     <= RESET_PC & 32'hFFFF_FFFC;
         r_inf_pc <= '0;
         r_inf    <= 1'b0;
         r_miss   <= '0;
      end else if (redirect_valid) begin
         r_pc  <= w_redir_pc;
         r_inf <= 1'b0;
      end else begin
         // A miss squashes whatever was issued alongside it.
         r_inf <= w_req && !w_resp_miss;
         if (w_req)
            r_inf_pc <= r_pc;
         if (w_resp_miss) begin
            r_pc <= r_inf_pc;
            if (r_miss != 32'hFFFF_FFFF)
               r_miss <= r_miss + 32'd1;
         end else if (w_req) begin
            r_pc <= r_pc + 32'd4;
         end
      end
   end

   fetch_queue #(
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_entry (w_entry),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign icache_req = w_req;
   assign icache_pc  = r_pc;
   assign if_valid   = !w_empty;
   assign if_pc      = w_head.pc;
   assign if_inst    = w_head.inst;
   assign miss_count = r_miss;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle I-cache model
// and an in-order delivery scoreboard.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        icache_req;
   logic [31:0] icache_pc;
   logic [31:0] icache_inst = '0;
   logic        icache_valid = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        if_valid;
   logic        if_ready = 1'b1;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic [31:0] miss_count;

   int checks = 0;
   int errors = 0;
   int n_miss = 0;
   int miss_lim = 0;
   int ndeliv = 0;
   logic [31:0] miss_pc = '0;
   logic [31:0] exp_pc = 32'h8000_0000;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .icache_req     (icache_req),
      .icache_pc      (icache_pc),
      .icache_inst    (icache_inst),
      .icache_valid   (icache_valid),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_inst        (if_inst),
      .miss_count     (miss_count)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Cache: answers next cycle; misses miss_pc until miss_lim misses seen.
   always begin
      logic        s_req;
      logic [31:0] s_pc;
      logic        s_miss;
      @(negedge clk);
      s_req  = icache_req;
      s_pc   = icache_pc;
      s_miss = s_req && (s_pc == miss_pc) && (n_miss < miss_lim);
      if (s_miss)
         n_miss++;
      @(posedge clk);
      #1;
      icache_inst  = inst_of(s_pc);
      icache_valid = s_req && !s_miss;
   end

   // Scoreboard: decode must see consecutive PCs from the last restart.
   always @(negedge clk) begin
      if (rst)
         exp_pc = 32'h8000_0000;
      else if (redirect_valid)
         exp_pc = redirect_pc & 32'hFFFF_FFFC;
      else if (if_valid && if_ready) begin
         chk("if_pc", if_pc, exp_pc);
         chk("if_inst", if_inst, inst_of(exp_pc));
         exp_pc = exp_pc + 32'd4;
         ndeliv++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] pc_tbl [10] = '{
      32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C,
      32'h8000_0008, 32'h8000_000C, 32'h8000_0008, 32'h8000_000C,
      32'h8000_0008, 32'h8000_000C
   };
   logic vld_tbl [10] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};

   initial begin
      int  n0;
      logic found;
      miss_pc  = 32'h8000_0008;
      miss_lim = 3;
      repeat (3) step();
      @(negedge clk);
      chk("rst_req", 32'(icache_req), 32'd0);
      chk("rst_pc", icache_pc, 32'h8000_0000);
      chk("rst_ifv", 32'(if_valid), 32'd0);
      chk("rst_miss", miss_count, 32'd0);

      // Start-up and three misses on 8000_0008.
      step();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("start_pc", icache_pc, pc_tbl[c]);
         chk("start_req", 32'(icache_req), 32'd1);
         chk("start_ifv", 32'(if_valid), 32'(vld_tbl[c]));
         step();
      end
      @(negedge clk);
      chk("after_miss_ifpc", if_pc, 32'h8000_0008);
      repeat (20) step();
      @(negedge clk);
      chk("miss_count", miss_count, 32'd3);

      // Decode stalls: queue fills to depth and requests stop.
      step();
      if_ready = 1'b0;
      repeat (10) step();
      @(negedge clk);
      chk("hold_req", 32'(icache_req), 32'd0);
      chk("hold_ifv", 32'(if_valid), 32'd1);
      chk("hold_depth", icache_pc - if_pc, 32'd16);

      // One pop, one refill request, then redirect with it in flight.
      step();
      if_ready = 1'b1;
      step();
      if_ready = 1'b0;
      @(negedge clk);
      chk("refill_req", 32'(icache_req), 32'd1);
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_1002;
      if_ready       = 1'b1;
      @(negedge clk);
      chk("redir_req", 32'(icache_req), 32'd0);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("redir_ifv", 32'(if_valid), 32'd0);
      chk("redir_pc", icache_pc, 32'h0000_1000);
      chk("redir_req1", 32'(icache_req), 32'd1);
      step();
      step();
      @(negedge clk);
      chk("redir_ifv2", 32'(if_valid), 32'd1);
      chk("redir_ifpc", if_pc, 32'h0000_1000);

      // Redirect together with a miss response and a pop.
      miss_pc  = 32'h0000_1040;
      miss_lim = n_miss + 1;
      found    = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clk);
         if (icache_req && icache_pc == 32'h0000_1040)
            found = 1'b1;
      end
      chk("seek_1040", 32'(found), 32'd1);
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_2000;
      @(negedge clk);
      chk("mr_pop_ifv", 32'(if_valid), 32'd1);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("mr_pc", icache_pc, 32'h0000_2000);
      chk("mr_ifv", 32'(if_valid), 32'd0);
      chk("mr_miss", miss_count, 32'd3);

      // Address wrap at the top of memory.
      repeat (6) step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("wrap_pc0", icache_pc, 32'hFFFF_FFF8);
      step();
      @(negedge clk);
      chk("wrap_pc1", icache_pc, 32'hFFFF_FFFC);
      step();
      @(negedge clk);
      chk("wrap_pc2", icache_pc, 32'h0000_0000);
      chk("wrap_ifpc", if_pc, 32'hFFFF_FFF8);
      repeat (6) step();

      // Reset mid-stream beats a simultaneous redirect.
      rst            = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_3000;
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("rst2_pc", icache_pc, 32'h8000_0000);
      chk("rst2_ifv", 32'(if_valid), 32'd0);
      chk("rst2_miss", miss_count, 32'd0);
      chk("rst2_req", 32'(icache_req), 32'd0);
      step();
      n0  = ndeliv;
      rst = 1'b0;
      repeat (20) step();
      chk("rst2_deliv", 32'(ndeliv - n0 >= 18), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 Parameter QDEPTH, default 4, fetch queue entries (power of two, 2..16).
REQ-003 clk  input  1  sole clock, all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 icache_req  output  1  request enable; icache_pc is looked up this cycle.
REQ-006 icache_pc  output  32  word-aligned fetch address, registered.
REQ-007 icache_inst  input  32  instruction for the previous cycle's request.
REQ-008 icache_valid  input  1  hit flag for the previous cycle's request; 0 = miss.
REQ-009 redirect_valid  input  1  branch/exception redirect strobe from execute.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 if_valid  output  1  queue head holds an instruction.
REQ-012 if_ready  input  1  decode accepts head this cycle.
REQ-013 if_pc  output  32  PC of queue head.
REQ-014 if_inst  output  32  instruction of queue head.
REQ-015 miss_count  output  32  saturating count of accepted miss responses.

Function
REQ-016 Cache protocol: request in cycle N (icache_req=1, icache_pc=P) -> icache_valid/icache_inst for P sampled in cycle N+1; at most one request per cycle.
REQ-017 FSM states: IDLE, RUN, HOLD; IDLE -> RUN on the first cycle after rst deasserts.
REQ-018 RUN: icache_req=1 iff (queue count + in-flight count) < QDEPTH; otherwise HOLD with icache_req=0; HOLD -> RUN when that condition becomes true.
REQ-019 On every issued request: inflight_pc <= icache_pc, icache_pc <= icache_pc + 4 (32-bit wrap, 32'hFFFF_FFFC -> 32'h0).
REQ-020 Non-squashed response with icache_valid=1: push {inflight_pc, icache_inst} into queue that cycle; visible on if_* the next cycle.
REQ-021 Non-squashed response with icache_valid=0: no push; icache_pc <= inflight_pc (rewind); any request issued in the same cycle is squashed; miss_count increments unless 32'hFFFF_FFFF.
REQ-022 Squashed responses are discarded regardless of icache_valid and do not count as misses.
REQ-023 Queue: FIFO; pop when if_valid && if_ready; simultaneous push and pop at full or empty allowed, count unchanged.
REQ-024 if_pc/if_inst are don't-care while if_valid=0; they are held stable while if_valid=1 && if_ready=0.
REQ-025 Redirect (highest priority): queue flushed, in-flight response squashed, icache_pc <= {redirect_pc[31:2],2'b00}, state RUN; push and pop in that cycle suppressed; first request with new PC issued the following cycle.
REQ-026 Redirect during a miss rewind: redirect wins; rewind address discarded.
REQ-027 Steady-state throughput: one instruction per cycle with continuous hits and if_ready=1; hit latency request-to-if_valid = 2 cycles.

Reset
REQ-028 While rst=1: icache_req=0, icache_pc=RESET_PC, queue empty (if_valid=0), no in-flight request, state IDLE, miss_count=0.
REQ-029 rst asserted mid-operation overrides redirect, push and pop in that cycle; in-flight responses arriving after reset deassertion are ignored.

Structure
REQ-030 Shared package fetch_pkg SHALL hold the FSM state enum, the queue entry struct {pc, inst}, and the RESET_PC default constant.
REQ-031 Queue SHALL be a separate sub-module fetch_queue (parameterised depth, push/pop/flush, count, full/empty).

Verification
REQ-032 Reset release, always-hit cache, if_ready=1 -> icache_pc 8000_0000, 8000_0004, ...; if_valid first at cycle 2; if_pc increments by 4 each cycle.
REQ-033 Miss on 8000_0008 for 3 responses then hit -> icache_pc rewinds to 8000_0008 each time; miss_count=3; if_inst order unbroken.
REQ-034 if_ready=0 for 10 cycles, all hits -> exactly 4 entries queued, icache_req=0 in HOLD, no lost or duplicated PCs after release.
REQ-035 redirect_pc=0000_1002 while queue full and a request in flight -> if_valid=0 next cycle, next icache_pc=0000_1000, stale response dropped.
REQ-036 Redirect in same cycle as miss response and pop -> icache_pc follows redirect, miss_count unchanged, queue empty.
REQ-037 redirect_pc=FFFF_FFF8, all hits -> fetched PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
